// File: rtl/tl_pkg.sv
// tl_pkg: definitions shared by the traffic-light side-road blocks.
//   LED_RED / LED_YEL / LED_GRN : bit positions inside the 3-bit lamp vector
//   state_t                     : request FSM states of vehicle_sensor_if
package tl_pkg;

   localparam int LED_RED = 2;
   localparam int LED_YEL = 1;
   localparam int LED_GRN = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      SERVE = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: conditions the asynchronous loop-detector level.
//   Two-flop synchroniser followed by a counter debounce: the synchronised
//   level must disagree with det_stable for DEB_CYCLES consecutive cycles
//   before det_stable follows it.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   raw_det    : asynchronous raw detector level (1 = vehicle present)
//   det_stable : registered debounced presence
//   rise       : combinational strobe, high on the cycle det_stable is about
//                to go 0->1 (lets the arrival counter update on the same edge)
module sensor_debounce
   import tl_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_det,
   output logic det_stable,
   output logic rise
);

   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   logic       sync_ff1;
   logic       sync_ff2;
   logic [7:0] deb_cnt;
   logic       differ;
   logic       toggle;

   assign differ = (sync_ff2 != det_stable);
   assign toggle = differ && (deb_cnt == DEB_LAST);
   assign rise   = toggle && !det_stable;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff1   <= 1'b0;
         sync_ff2   <= 1'b0;
         deb_cnt    <= 8'd0;
         det_stable <= 1'b0;
      end else begin
         sync_ff1 <= raw_det;
         sync_ff2 <= sync_ff1;
         // Any agreeing cycle restarts the run, so short glitches never toggle.
         if (!differ) begin
            deb_cnt <= 8'd0;
         end else if (toggle) begin
            det_stable <= ~det_stable;
            deb_cnt    <= 8'd0;
         end else begin
            deb_cnt <= deb_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/vehicle_sensor_if.sv
// vehicle_sensor_if: side-road vehicle-detector front end.
//   Debounces the loop detector, latches a request for the highway controller
//   until the side road has had its green, then holds further requests off for
//   HOLD_SEC one-second ticks after the green ends.
// Optional build macro SENSOR_TIMEOUT_EN: adds a stuck-detector that raises
//   fault after MAX_SEC ticks of continuous presence and suppresses requests
//   until the detector releases. Without it fault is constant 0.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   raw_det    : asynchronous raw detector level (1 = vehicle present)
//   pulse      : one-cycle 1 s tick
//   cr_led     : side-road lamps {red, yellow, green}
//   sensor     : registered request to the highway controller
//   det_stable : registered debounced presence
//   veh_count  : saturating count of debounced arrivals
//   fault      : stuck-detector flag
module vehicle_sensor_if
   import tl_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int HOLD_SEC   = 3
`ifdef SENSOR_TIMEOUT_EN
   ,
   parameter int MAX_SEC    = 60
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_det,
   input  logic       pulse,
   input  logic [2:0] cr_led,
   output logic       sensor,
   output logic       det_stable,
   output logic [7:0] veh_count,
   output logic       fault
);

   localparam logic [5:0] HOLD_LAST = 6'(HOLD_SEC);

   state_t     state;
   state_t     next_state;
   logic [5:0] hold_cnt;
   logic       sensor_d;
   logic       fault_d;
   logic       det_rise;
   logic       green;
   logic       unused_led;

   // Only the green lamp matters; red/yellow and illegal codes are ignored.
   assign green      = cr_led[LED_GRN];
   assign unused_led = ^cr_led[LED_RED:LED_YEL];

   sensor_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .raw_det   (raw_det),
      .det_stable(det_stable),
      .rise      (det_rise)
   );

   // Arrival counter, saturating at 255.
   always_ff @(posedge clk) begin
      if (rst) begin
         veh_count <= 8'd0;
      end else if (det_rise && (veh_count != 8'hFF)) begin
         veh_count <= veh_count + 8'd1;
      end
   end

`ifdef SENSOR_TIMEOUT_EN
   localparam logic [7:0] STUCK_LIMIT = 8'(MAX_SEC);

   logic [7:0] stuck_cnt;

   // Fault persists while presence persists and drops the edge after release.
   assign fault_d = det_stable && (fault || (stuck_cnt == STUCK_LIMIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         stuck_cnt <= 8'd0;
         fault     <= 1'b0;
      end else begin
         fault <= fault_d;
         if (!det_stable) begin
            stuck_cnt <= 8'd0;
         end else if (pulse && (stuck_cnt != STUCK_LIMIT)) begin
            stuck_cnt <= stuck_cnt + 8'd1;
         end
      end
   end
`else
   assign fault_d = 1'b0;
   assign fault   = 1'b0;
`endif

   // State register plus the registered request output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sensor <= 1'b0;
      end else begin
         state  <= next_state;
         sensor <= sensor_d;
      end
   end

   // Hold-off tick counter; zero in every other state so HOLD always starts at 0.
   always_ff @(posedge clk) begin
      if (rst || (state != HOLD)) begin
         hold_cnt <= 6'd0;
      end else if (pulse) begin
         hold_cnt <= hold_cnt + 6'd1;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (det_stable)            next_state = REQ;
         REQ:     if (green)                 next_state = SERVE;
         SERVE:   if (!green)                next_state = HOLD;
         HOLD:    if (hold_cnt == HOLD_LAST) next_state = IDLE;
         default:                            next_state = IDLE;
      endcase
      if (fault_d) next_state = IDLE;
   end

   // Output decode from the upcoming state so sensor lands with the state.
   always_comb begin
      sensor_d = 1'b0;
      unique case (next_state)
         REQ:     sensor_d = 1'b1;
         SERVE:   sensor_d = det_stable;
         default: sensor_d = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_vehicle_sensor_if.sv
// Bench for vehicle_sensor_if (DEB_CYCLES = 4, HOLD_SEC = 3, pulse every 20 clk).
module tb_vehicle_sensor_if;

   localparam int DEB      = 4;
   localparam int HOLD     = 3;
   localparam int TB_MAX   = 5;
`ifdef SENSOR_TIMEOUT_EN
   localparam bit TO_EN    = 1'b1;
`else
   localparam bit TO_EN    = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       raw_det;
   logic       pulse;
   logic [2:0] cr_led;
   logic       sensor;
   logic       det_stable;
   logic [7:0] veh_count;
   logic       fault;

   always #5 clk = ~clk;

   vehicle_sensor_if #(
      .DEB_CYCLES(DEB),
      .HOLD_SEC  (HOLD)
`ifdef SENSOR_TIMEOUT_EN
      ,
      .MAX_SEC   (TB_MAX)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .raw_det   (raw_det),
      .pulse     (pulse),
      .cr_led    (cr_led),
      .sensor    (sensor),
      .det_stable(det_stable),
      .veh_count (veh_count),
      .fault     (fault)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Request lifecycle: waiting for green -> in green -> hold-off ticks -> idle.
   bit m_valid = 1'b0;
   bit m_s1, m_s2;
   bit m_hist[$];
   bit m_det, m_sensor, m_fault;
   bit m_wait_green, m_in_green;
   int m_hold_ticks;   // -1 when not holding off
   int m_veh, m_secs;

   always @(posedge clk) begin
      bit det_old, sync_old, all_diff, fault_new;
      if (rst) begin
         m_valid = 1'b1;
         m_s1 = 0; m_s2 = 0; m_hist.delete();
         m_det = 0; m_sensor = 0; m_fault = 0;
         m_wait_green = 0; m_in_green = 0; m_hold_ticks = -1;
         m_veh = 0; m_secs = 0;
      end else if (m_valid) begin
         det_old  = m_det;
         sync_old = m_s2;
         m_s2 = m_s1;
         m_s1 = raw_det;
         // presence flips once the last DEB synchronised samples all disagree
         m_hist.push_back(sync_old);
         if (m_hist.size() > DEB) void'(m_hist.pop_front());
         all_diff = (m_hist.size() == DEB);
         foreach (m_hist[i]) if (m_hist[i] == det_old) all_diff = 0;
         if (all_diff) begin
            m_det = !det_old;
            m_hist.delete();
            if (m_det && m_veh < 255) m_veh++;
         end
         if (m_hold_ticks >= 0) begin
            if (m_hold_ticks == HOLD) m_hold_ticks = -1;
            else if (pulse) m_hold_ticks++;
         end else if (m_in_green) begin
            if (!cr_led[0]) begin m_in_green = 0; m_hold_ticks = 0; end
         end else if (m_wait_green) begin
            if (cr_led[0]) begin m_wait_green = 0; m_in_green = 1; end
         end else if (det_old) begin
            m_wait_green = 1;
         end
         if (TO_EN) begin
            fault_new = det_old && (m_fault || m_secs == TB_MAX);
            if (!det_old) m_secs = 0;
            else if (pulse && m_secs < TB_MAX) m_secs++;
            m_fault = fault_new;
            if (m_fault) begin
               m_wait_green = 0; m_in_green = 0; m_hold_ticks = -1;
            end
         end
         m_sensor = !m_fault && (m_wait_green || (m_in_green && det_old));
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         check("cmp_sensor", sensor, m_sensor);
         check("cmp_det_stable", det_stable, m_det);
         check("cmp_veh_count", veh_count, m_veh);
         check("cmp_fault", fault, m_fault);
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(negedge clk);
      cyc++;
      pulse = (cyc % 20 == 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  ticks, after, e;
      bit  p, done;
      rst = 1'b1; raw_det = 1'b0; pulse = 1'b0; cr_led = 3'b100;

      // reset
      repeat (3) step();
      check("rst_sensor", sensor, 0);
      check("rst_det", det_stable, 0);
      check("rst_veh", veh_count, 0);
      check("rst_fault", fault, 0);
      rst = 1'b0;

      // glitches of 3 clk are rejected
      repeat (5) begin
         raw_det = 1'b1; repeat (3) step();
         raw_det = 1'b0; repeat (6) step();
      end
      check("glitch_det", det_stable, 0);
      check("glitch_sensor", sensor, 0);
      check("glitch_veh", veh_count, 0);

      // debounce + request latency
      raw_det = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         if (i == 5) check("lat_det_e5", det_stable, 0);
         if (i == 6) begin
            check("lat_det_e6", det_stable, 1);
            check("lat_sensor_e6", sensor, 0);
         end
         if (i == 7) begin
            check("lat_sensor_e7", sensor, 1);
            check("lat_veh", veh_count, 1);
            check("model_veh_pin", m_veh, 1);
         end
      end

      // request latched until served
      raw_det = 1'b0;
      repeat (100) begin
         step();
         check("latch_sensor", sensor, 1);
      end
      check("latch_det_gone", det_stable, 0);
      cr_led = 3'b001;
      step();
      check("serve_empty_sensor", sensor, 0);

      // hold-off after green
      raw_det = 1'b1;
      repeat (7) step();
      check("serve_sensor", sensor, 1);
      check("serve_veh", veh_count, 2);
      cr_led = 3'b010;
      step();
      check("hold_enter_sensor", sensor, 0);
      ticks = 0; after = -1; done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         p = pulse;
         step();
         if (after >= 0) after++;
         else if (p) begin
            ticks++;
            if (ticks == HOLD) after = 0;
         end
         if (after == 2) begin
            check("hold_release_sensor", sensor, 1);
            check("model_sensor_pin", m_sensor, 1);
            done = 1;
         end else begin
            check("hold_block_sensor", sensor, 0);
         end
      end
      if (!done) check("hold_release_timeout", 0, 1);

      // reset mid-operation in REQ
      rst = 1'b1;
      step();
      check("midrst_sensor", sensor, 0);
      check("midrst_veh", veh_count, 0);
      check("midrst_det", det_stable, 0);
      rst = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
         if (i == 6) check("midrst_sensor_e6", sensor, 0);
         if (i == 7) begin
            check("midrst_sensor_e7", sensor, 1);
            check("midrst_veh_e7", veh_count, 1);
         end
      end

`ifdef SENSOR_TIMEOUT_EN
      // stuck detector
      raw_det = 1'b0;
      repeat (30) step();
      check("to_fault_idle", fault, 0);
      raw_det = 1'b1;
      e = 0; ticks = 0; done = 0;
      for (int k = 0; k < 400 && !done; k++) begin
         p = pulse;
         step();
         e++;
         if (ticks == TB_MAX) begin
            check("to_fault_set", fault, 1);
            check("to_sensor_off", sensor, 0);
            done = 1;
         end else if (e >= 7 && p) begin
            ticks++;
            if (ticks == TB_MAX) check("to_fault_not_yet", fault, 0);
         end
      end
      if (!done) check("to_fault_timeout", 0, 1);
      repeat (25) step();
      check("to_fault_held", fault, 1);
      check("to_sensor_held", sensor, 0);
      raw_det = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
         if (i == 6) check("to_fault_e6", fault, 1);
         if (i == 7) check("to_fault_e7", fault, 0);
      end
`endif

      repeat (5) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
